// File: rtl/dmem_block_memory_pkg.sv
// Shared definitions for the block-granular data memory model and its helpers.
// Width defaults apply only when the shared constants file has not defined them.
`ifndef DMEM_BLOCK_ADDR_SIZE
`define DMEM_BLOCK_ADDR_SIZE 6
`endif
`ifndef DBLOCK_SIZE_BITS
`define DBLOCK_SIZE_BITS 128
`endif

package dmem_block_memory_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_DONE = 3'd2,
        WR_WAIT = 3'd3,
        WR_DONE = 3'd4
    } mem_state_t;

    localparam int DEFAULT_LATENCY = 10;
    localparam int DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/dmem_block_memory_latency_counter.sv
// Loadable down-counter with a zero flag; sized for access-latency timing
// and shared by the data-side and instruction-side memory models.
module dmem_block_memory_latency_counter
    import dmem_block_memory_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load wins over decrement; the count parks at zero rather than wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dmem_block_memory.sv
// Block-granular main memory behind the D-cache miss controller: whole-block
// refills and write-backs, each completed by a one-cycle pulse after LATENCY.
module dmem_block_memory
    import dmem_block_memory_pkg::*;
#(
    parameter int BLOCK_ADDR_W = `DMEM_BLOCK_ADDR_SIZE,
    parameter int BLOCK_BITS   = `DBLOCK_SIZE_BITS,
    parameter int DEPTH        = 2**BLOCK_ADDR_W,
    parameter int LATENCY      = DEFAULT_LATENCY,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    memRen,
    input  logic                    memWen,
    input  logic [BLOCK_ADDR_W-1:0] BlockAddr,
    input  logic [BLOCK_BITS-1:0]   memDin,
    output logic [BLOCK_BITS-1:0]   memDout,
    output logic                    memReadReady,
    output logic                    memWriteDone
);

    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(LATENCY - 1);

    mem_state_t              state;
    logic [BLOCK_BITS-1:0]   mem [DEPTH];
    logic [BLOCK_ADDR_W-1:0] addr_q;
    logic [BLOCK_BITS-1:0]   data_q;
    logic                    cnt_zero;
    logic                    accept_wr;
    logic                    accept_rd;
    logic                    in_wait;
    logic                    commit_wr;

    assign accept_wr = (state == IDLE) && memWen;
    assign accept_rd = (state == IDLE) && !memWen && memRen;
    assign in_wait   = (state == RD_WAIT) || (state == WR_WAIT);
    // A write lands only if the request survives to the final wait cycle.
    assign commit_wr = (state == WR_WAIT) && memWen && cnt_zero;

    dmem_block_memory_latency_counter #(
        .CNT_W(CNT_W)
    ) u_latency_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (accept_wr || accept_rd),
        .load_value (LOAD_VALUE),
        .dec        (in_wait),
        .zero       (cnt_zero)
    );

    // Request capture and storage carry no reset; contents survive reset.
    always_ff @(posedge clock) begin
        if (accept_wr || accept_rd) begin
            addr_q <= BlockAddr;
        end
        if (accept_wr) begin
            data_q <= memDin;
        end
        if (commit_wr) begin
            mem[addr_q] <= data_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            memDout      <= '0;
            memReadReady <= 1'b0;
            memWriteDone <= 1'b0;
        end else begin
            memReadReady <= 1'b0;
            memWriteDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (memWen) begin
                        state <= WR_WAIT;
                    end else if (memRen) begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (!memRen) begin
                        state <= IDLE;
                    end else if (cnt_zero) begin
                        state        <= RD_DONE;
                        memReadReady <= 1'b1;
                        memDout      <= mem[addr_q];
                    end
                end
                WR_WAIT: begin
                    if (!memWen) begin
                        state <= IDLE;
                    end else if (cnt_zero) begin
                        state        <= WR_DONE;
                        memWriteDone <= 1'b1;
                    end
                end
                // Done states always pass through IDLE so a held request is not re-accepted.
                RD_DONE, WR_DONE: state <= IDLE;
                default:          state <= IDLE;
            endcase
        end
    end

endmodule
